wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Merges the three result streams of the ALU/MEM/IO execution unit (alu, mem and io address/value pairs) into the single register-file write port.
- A destination address of 0 means "no write".
- Each source has a small FIFO. A round-robin (or fixed-priority) arbiter drains one result per cycle.
- Drives a stall signal back to issue, and answers a pending-write query for hazard detection.

Parameters:
- DEPTH, 4, entries per source FIFO (power of 2, >=2)
- ADDR_W, 6, register address width
- DATA_W, 32, result value width

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock, synchronous, active-low
- alu_addr  in  ADDR_W  ALU result destination; 0 = none
- alu_dd_val  in  DATA_W  ALU result value
- mem_addr  in  ADDR_W  load result destination; 0 = none
- mem_dd_val  in  DATA_W  load result value
- io_addr  in  ADDR_W  IN result destination; 0 = none
- io_dd_val  in  DATA_W  IN result value
- wb_addr  out  ADDR_W  register-file write address (registered); 0 = no write
- wb_val  out  DATA_W  register-file write data (registered)
- stall  out  1  issue must hold
- q_addr  in  ADDR_W  pending-write query address
- q_hit  out  1  q_addr has a pending, not-yet-written result (combinational)
- ovf  out  1  sticky: a result was dropped

Behaviour:
- Reset (rstn=0 at posedge):
  - wb_addr=0, wb_val=0, ovf=0.
  - All FIFOs emptied; read/write pointers and counts = 0; round-robin pointer = mem.
  - Reset mid-operation discards all queued results.
- Valid input: a source presents a result when its addr != 0. Results with addr 0 are never enqueued or written.
- Candidate per source:
  - FIFO non-empty: the FIFO head.
  - FIFO empty: the incoming valid result (bypass).
- Arbitration (one winner per cycle):
  - Default is round-robin, order mem -> alu -> io.
  - The pointer advances to the source after the winner.
  - The pointer is unchanged when there are no candidates.
- Winner → wb_addr/wb_val at the next posedge. Latency is 1 cycle for a bypassed result.
- No candidate: wb_addr <= 0 and wb_val holds its value.
- Losing or queued inputs:
  - A valid input not consumed by bypass is pushed to its FIFO the same edge.
  - A FIFO whose head wins is popped.
  - Simultaneous push and pop on one FIFO: count unchanged, order preserved.
- Full FIFO:
  - A push to a full FIFO with no same-cycle pop drops the input and sets ovf=1.
  - ovf clears only on reset.
  - Push with simultaneous pop on a full FIFO is legal.
- Pointers wrap modulo DEPTH.
- stall = 1 when any FIFO count >= DEPTH-1 (registered from next-state counts). This gives one slot of margin for the in-flight memory pipeline result.
- q_hit = 1 when:
  - any valid FIFO entry has addr == q_addr, or
  - the wb_addr register equals q_addr.
  - q_addr == 0 always gives q_hit=0.
- Ordering: within one source, results are written in arrival order. No ordering is guaranteed across sources; issue uses q_hit to prevent WAW hazards.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority mem > alu > io; the round-robin pointer is removed.
- Undefined: round-robin as above.
- In both builds a source with a non-empty FIFO never loses to its own bypass input.

Decomposition:
- Shared package holds:
  - ADDR_W/DATA_W constants.
  - Source index enum (SRC_MEM=0, SRC_ALU=1, SRC_IO=2).
  - wb_entry struct {addr, val}.
- Natural sub-module: wb_fifo (DEPTH-entry FIFO with count and per-entry addr-match output for q_hit), instantiated three times.
- The arbiter and output register live in wb_arbiter.

Test Plan:
- Single ALU result: alu_addr=5, val=0x1234 for one cycle with queues empty → next cycle wb_addr=5, wb_val=0x1234; following cycle wb_addr=0.
- Simultaneous inputs: mem=3/0xA, alu=4/0xB, io=7/0xC in one cycle → writes appear on three consecutive cycles in order 3, 4, 7 (round-robin from reset). Under WB_ARB_FIXED_PRIO_EN the order is also 3, 4, 7.
- Fairness: alu and mem valid every cycle for 8 cycles → writes alternate mem/alu, no starvation; stall asserts once alu FIFO count reaches 3 (DEPTH=4).
- Overflow: io FIFO full (4 entries, mem saturating and fixed priority), a further io input arrives → input dropped, ovf=1 and stays 1 until rstn=0.
- Hazard query: alu result addr 9 queued behind mem traffic, q_addr=9 → q_hit=1 until the cycle after wb_addr=9 is written; q_addr=0 → q_hit=0.
- Reset mid-operation: queue 3 entries, assert rstn=0 for one cycle → wb_addr=0, stall=0, q_hit=0, and no queued write ever appears afterwards.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the write-back arbiter: widths, source index, result entry.
package wb_arbiter_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int NSRC   = 3;

  typedef enum logic [1:0] {SRC_MEM = 2'd0, SRC_ALU = 2'd1, SRC_IO = 2'd2} src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
  } wb_entry_t;

  // (base + k) mod NSRC on 2-bit source indices
  function automatic logic [1:0] rot(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] t;
    t = {1'b0, base} + {1'b0, k};
    return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO with occupancy count and pending-address match.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      push,
  input  logic                      pop,
  input  wb_entry_t                 din,
  input  logic [ADDR_W-1:0]         q_addr,
  output wb_entry_t                 head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      match
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd, wr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= din;
  end

  assign head  = mem[rd];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && mem[rd + PW'(i)].addr == q_addr) match = 1'b1;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU/MEM/IO results into one register-file write port.
// WB_ARB_FIXED_PRIO_EN: fixed mem > alu > io priority instead of round-robin.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_dd_val,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dd_val,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_dd_val,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_val,
  output logic              stall,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit,
  output logic              ovf
);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t         in_e [NSRC];
  wb_entry_t         head [NSRC];
  wb_entry_t         cand [NSRC];
  wb_entry_t         win_e;
  logic [CW-1:0]     count    [NSRC];
  logic [CW-1:0]     count_nx [NSRC];
  logic [NSRC-1:0]   in_vld, cand_vld, empty, full, match;
  logic [NSRC-1:0]   gnt, pop, push_req, push, drop, near_full;
  logic [1:0]        sel;
  logic              any;
`ifndef WB_ARB_FIXED_PRIO_EN
  src_e              rr;
`endif

  assign in_e[SRC_MEM] = '{addr: mem_addr, val: mem_dd_val};
  assign in_e[SRC_ALU] = '{addr: alu_addr, val: alu_dd_val};
  assign in_e[SRC_IO]  = '{addr: io_addr,  val: io_dd_val};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign in_vld[g]   = (in_e[g].addr != '0);
    // a queued head always beats this source's own bypass input
    assign cand_vld[g] = ~empty[g] | in_vld[g];
    assign cand[g]     = empty[g] ? in_e[g] : head[g];
    assign pop[g]      = gnt[g] & ~empty[g];
    assign push_req[g] = in_vld[g] & ~(gnt[g] & empty[g]);
    assign push[g]     = push_req[g] & (~full[g] | pop[g]);
    assign drop[g]     = push_req[g] & full[g] & ~pop[g];
    assign count_nx[g] = count[g] + CW'(push[g]) - CW'(pop[g]);
    assign near_full[g] = (count_nx[g] >= CW'(DEPTH - 1));

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .push   (push[g]),
      .pop    (pop[g]),
      .din    (in_e[g]),
      .q_addr (q_addr),
      .head   (head[g]),
      .count  (count[g]),
      .empty  (empty[g]),
      .full   (full[g]),
      .match  (match[g])
    );
  end

  // scan from lowest priority upward so the highest-priority candidate is kept
  always_comb begin
    any = 1'b0;
    sel = 2'd0;
    gnt = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
`ifdef WB_ARB_FIXED_PRIO_EN
      if (cand_vld[2'(k)]) begin
        any = 1'b1;
        sel = 2'(k);
      end
`else
      if (cand_vld[rot(rr, 2'(k))]) begin
        any = 1'b1;
        sel = rot(rr, 2'(k));
      end
`endif
    end
    if (any) gnt[sel] = 1'b1;
    win_e = cand[sel];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_addr <= '0;
      wb_val  <= '0;
      ovf     <= 1'b0;
      stall   <= 1'b0;
`ifndef WB_ARB_FIXED_PRIO_EN
      rr      <= SRC_MEM;
`endif
    end else begin
      if (any) begin
        wb_addr <= win_e.addr;
        wb_val  <= win_e.val;
`ifndef WB_ARB_FIXED_PRIO_EN
        rr      <= src_e'(rot(sel, 2'd1));
`endif
      end else begin
        wb_addr <= '0;
      end
      ovf   <= ovf | (|drop);
      stall <= |near_full;
    end
  end

  assign q_hit = (q_addr != '0) && ((|match) || (wb_addr == q_addr));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + random bench for wb_arbiter against a queue-level reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int D = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [ADDR_W-1:0] alu_addr = '0, mem_addr = '0, io_addr = '0, q_addr = '0;
  logic [DATA_W-1:0] alu_dd_val = '0, mem_dd_val = '0, io_dd_val = '0;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_val;
  logic              stall, q_hit, ovf;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(D)) dut (
    .clk(clk), .rstn(rstn),
    .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
    .mem_addr(mem_addr), .mem_dd_val(mem_dd_val),
    .io_addr(io_addr), .io_dd_val(io_dd_val),
    .wb_addr(wb_addr), .wb_val(wb_val), .stall(stall),
    .q_addr(q_addr), .q_hit(q_hit), .ovf(ovf)
  );

  int total = 0;
  int bad   = 0;

  // reference model: per-source in-order lists (index 0 = oldest), 0=mem 1=alu 2=io
  logic [ADDR_W-1:0] fa [3][D];
  logic [DATA_W-1:0] fv [3][D];
  int                fcnt [3];
  int                rr;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_val;
  logic              e_ovf, e_stall;
  logic [ADDR_W-1:0] ia [3];
  logic [DATA_W-1:0] iv [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_qhit(input logic [ADDR_W-1:0] a);
    if (a == 0) return 1'b0;
    if (e_addr == a) return 1'b1;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < fcnt[s]; i++)
        if (fa[s][i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) fcnt[s] = 0;
    rr = 0; e_addr = '0; e_val = '0; e_ovf = 1'b0; e_stall = 1'b0;
  endtask

  task automatic model_clk();
    int  win;
    bit  byp;
    win = -1;
    byp = 0;
`ifdef WB_ARB_FIXED_PRIO_EN
    for (int s = 0; s < 3; s++)
      if (win < 0 && (fcnt[s] > 0 || ia[s] != 0)) win = s;
`else
    for (int k = 0; k < 3; k++)
      if (win < 0 && (fcnt[(rr + k) % 3] > 0 || ia[(rr + k) % 3] != 0)) win = (rr + k) % 3;
`endif
    if (win >= 0) begin
      if (fcnt[win] > 0) begin
        e_addr = fa[win][0];
        e_val  = fv[win][0];
        for (int i = 0; i < D - 1; i++) begin
          fa[win][i] = fa[win][i+1];
          fv[win][i] = fv[win][i+1];
        end
        fcnt[win]--;
      end else begin
        e_addr = ia[win];
        e_val  = iv[win];
        byp    = 1;
      end
      rr = (win + 1) % 3;
    end else begin
      e_addr = '0;
    end
    for (int s = 0; s < 3; s++) begin
      if (ia[s] != 0 && !(byp && s == win)) begin
        if (fcnt[s] < D) begin
          fa[s][fcnt[s]] = ia[s];
          fv[s][fcnt[s]] = iv[s];
          fcnt[s]++;
        end else e_ovf = 1'b1;
      end
    end
    e_stall = 1'b0;
    for (int s = 0; s < 3; s++) if (fcnt[s] >= D - 1) e_stall = 1'b1;
  endtask

  task automatic step(input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] mv,
                      input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] av,
                      input logic [ADDR_W-1:0] xa, input logic [DATA_W-1:0] xv,
                      input logic [ADDR_W-1:0] qa);
    mem_addr = ma; mem_dd_val = mv; alu_addr = aa; alu_dd_val = av;
    io_addr = xa; io_dd_val = xv; q_addr = qa;
    ia[0] = ma; iv[0] = mv; ia[1] = aa; iv[1] = av; ia[2] = xa; iv[2] = xv;
    #1;
    chk("q_hit", {63'd0, q_hit}, {63'd0, model_qhit(qa)});
    @(posedge clk); #1;
    model_clk();
    chk("wb_addr", 64'(wb_addr), 64'(e_addr));
    chk("wb_val", 64'(wb_val), 64'(e_val));
    chk("ovf", {63'd0, ovf}, {63'd0, e_ovf});
    chk("stall", {63'd0, stall}, {63'd0, e_stall});
  endtask

  task automatic idle(input logic [ADDR_W-1:0] qa);
    step('0, '0, '0, '0, '0, '0, qa);
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] qa);
    rstn = 1'b0;
    mem_addr = '0; alu_addr = '0; io_addr = '0; q_addr = qa;
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    chk("rst_wb_addr", 64'(wb_addr), 64'd0);
    chk("rst_wb_val", 64'(wb_val), 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_q_hit", {63'd0, q_hit}, 64'd0);
  endtask

  initial begin
    model_reset();
    do_reset('0);

    // single ALU result, 1-cycle bypass latency
    step('0, '0, 6'd5, 32'h1234, '0, '0, '0);
    chk("single_addr", 64'(wb_addr), 64'd5);
    chk("single_val", 64'(wb_val), 64'h1234);
    idle('0);
    chk("single_after", 64'(wb_addr), 64'd0);

    // simultaneous inputs drain in order 3, 4, 7
    do_reset('0);
    step(6'd3, 32'hA, 6'd4, 32'hB, 6'd7, 32'hC, 6'd7);
    chk("order0", 64'(wb_addr), 64'd3);
    idle(6'd7);
    chk("order1", 64'(wb_addr), 64'd4);
    idle(6'd7);
    chk("order2", 64'(wb_addr), 64'd7);
    idle(6'd7);
    idle(6'd7);

    // alu + mem every cycle: fairness and stall build-up
    do_reset('0);
    for (int i = 0; i < 8; i++)
      step(6'(10 + i), 32'(i), 6'(20 + i), 32'(100 + i), '0, '0, 6'(20 + i));
    for (int i = 0; i < 10; i++) idle(6'd25);

    // hazard query: alu 9 behind mem traffic
    do_reset('0);
    step(6'd11, 32'h11, '0, '0, '0, '0, 6'd9);
    step(6'd12, 32'h12, 6'd9, 32'h99, '0, '0, 6'd9);
    step(6'd13, 32'h13, '0, '0, '0, '0, 6'd9);
    for (int i = 0; i < 5; i++) idle(6'd9);
    idle('0);

    // overflow: all three sources saturate
    do_reset('0);
    for (int i = 0; i < 8; i++)
      step(6'(1 + i), 32'(i), 6'(30 + i), 32'(i), 6'(40 + i), 32'(i), '0);
    chk("ovf_set", {63'd0, ovf}, 64'd1);
    for (int i = 0; i < 16; i++) idle(6'd40);
    chk("ovf_sticky", {63'd0, ovf}, 64'd1);
    do_reset(6'd40);

    // reset mid-operation discards queued results
    step(6'd3, 32'h1, 6'd4, 32'h2, 6'd7, 32'h3, '0);
    step(6'd5, 32'h4, 6'd6, 32'h5, '0, '0, '0);
    do_reset(6'd6);
    for (int i = 0; i < 5; i++) idle(6'd6);

    // random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      int dens;
      if (n % 200 == 150) do_reset(6'($urandom_range(0, 15)));
      dens = (n % 100 < 50) ? 3 : 8;
      step(($urandom_range(0, 9) < dens) ? 6'($urandom_range(0, 15)) : 6'd0, $urandom,
           ($urandom_range(0, 9) < dens) ? 6'($urandom_range(0, 15)) : 6'd0, $urandom,
           ($urandom_range(0, 9) < dens) ? 6'($urandom_range(0, 15)) : 6'd0, $urandom,
           6'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
